uart_cmd_parser: RTL and testbench



---
 rtl/uart_cmd_parser_pkg.sv | 24 ++
 rtl/uart_cmd_parser_timer.sv | 26 ++
 rtl/uart_cmd_parser.sv | 104 ++++++++++
 tb/tb_uart_cmd_parser.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_parser_pkg.sv
// Shared constants, state encoding and checksum helper for the UART command parser.
package uart_cmd_parser_pkg;
    localparam logic [7:0] HDR_BYTE    = 8'hA5;
    localparam logic [7:0] CMD_SET_RPM = 8'h01;
    localparam logic [7:0] CMD_STOP    = 8'h02;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_CHK  = 2'd1;
    localparam logic [1:0] ERR_CMD  = 2'd2;
    localparam logic [1:0] ERR_TMO  = 2'd3;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CMD  = 3'd1,
        DHI  = 3'd2,
        DLO  = 3'd3,
        CHK  = 3'd4
    } state_e;

    function automatic logic [7:0] frame_sum(input logic [7:0] a, input logic [7:0] b,
                                             input logic [7:0] c);
        return a + b + c;
    endfunction
endpackage

// File: rtl/uart_cmd_parser_timer.sv
// Inter-byte idle timer: counts stalled cycles inside a frame, flags the terminal count.
module cmd_timeout_timer #(
    parameter int unsigned TIMEOUT_CLKS = 270_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic run_i,
    output logic expired_o
);
    localparam int unsigned CW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [CW-1:0] TERM = CW'(TIMEOUT_CLKS - 1);

    logic [CW-1:0] cnt_q;

    assign expired_o = run_i && (cnt_q == TERM);

    // Holds at the terminal count; the parser drops to IDLE, which clears it.
    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            cnt_q <= '0;
        end else if (run_i && !expired_o) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
endmodule

// File: rtl/uart_cmd_parser.sv
// Assembles 5-byte command frames from the UART byte stream into a saturated RPM setpoint.
module uart_cmd_parser
    import uart_cmd_parser_pkg::*;
#(
    parameter int unsigned CLK_FREQ     = 27_000_000,
    parameter int unsigned TIMEOUT_CLKS = 270_000,
    parameter int          RPM_MAX      = 300
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_data_valid_i,
    input  logic [7:0]  rx_data_i,
    output logic [15:0] rpm_target_o,
    output logic        rpm_valid_o,
    output logic        frame_err_o,
    output logic [1:0]  err_code_o
);
    localparam logic signed [15:0] RPM_POS = 16'(RPM_MAX);
    localparam logic signed [15:0] RPM_NEG = -RPM_POS;

    state_e             state_q;
    logic [7:0]         cmd_q, dhi_q, dlo_q;
    logic signed [15:0] rpm_q;
    logic               rpm_valid_q, frame_err_q;
    logic [1:0]         err_code_q;
    logic               tmo_expired;
    logic signed [15:0] data_s, sat_s;

    cmd_timeout_timer #(.TIMEOUT_CLKS(TIMEOUT_CLKS)) u_timer (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (rx_data_valid_i || (state_q == IDLE)),
        .run_i     (state_q != IDLE),
        .expired_o (tmo_expired)
    );

    always_comb begin
        data_s = signed'({dhi_q, dlo_q});
        sat_s  = data_s;
        if (data_s > RPM_POS)      sat_s = RPM_POS;
        else if (data_s < RPM_NEG) sat_s = RPM_NEG;
    end

    // A byte arriving on the terminal-count cycle takes priority over the timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cmd_q       <= '0;
            dhi_q       <= '0;
            dlo_q       <= '0;
            rpm_q       <= '0;
            rpm_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            err_code_q  <= ERR_NONE;
        end else begin
            rpm_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            err_code_q  <= ERR_NONE;
            if (rx_data_valid_i) begin
                unique case (state_q)
                    IDLE: if (rx_data_i == HDR_BYTE) state_q <= CMD;
                    CMD: begin
                        cmd_q   <= rx_data_i;
                        state_q <= DHI;
                    end
                    DHI: begin
                        dhi_q   <= rx_data_i;
                        state_q <= DLO;
                    end
                    DLO: begin
                        dlo_q   <= rx_data_i;
                        state_q <= CHK;
                    end
                    CHK: begin
                        state_q <= IDLE;
                        if (rx_data_i != frame_sum(cmd_q, dhi_q, dlo_q)) begin
                            frame_err_q <= 1'b1;
                            err_code_q  <= ERR_CHK;
                        end else if (cmd_q == CMD_SET_RPM) begin
                            rpm_q       <= sat_s;
                            rpm_valid_q <= 1'b1;
                        end else if (cmd_q == CMD_STOP) begin
                            rpm_q       <= '0;
                            rpm_valid_q <= 1'b1;
                        end else begin
                            frame_err_q <= 1'b1;
                            err_code_q  <= ERR_CMD;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end else if (tmo_expired) begin
                state_q     <= IDLE;
                frame_err_q <= 1'b1;
                err_code_q  <= ERR_TMO;
            end
        end
    end

    assign rpm_target_o = rpm_q;
    assign rpm_valid_o  = rpm_valid_q;
    assign frame_err_o  = frame_err_q;
    assign err_code_o   = err_code_q;
endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser: frame table plus timeout, noise and reset sequences.
module tb_uart_cmd_parser;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_data_valid_i = 1'b0;
    logic [7:0]  rx_data_i = 8'h00;
    logic [15:0] rpm_target_o;
    logic        rpm_valid_o;
    logic        frame_err_o;
    logic [1:0]  err_code_o;

    int n_chk  = 0;
    int n_fail = 0;

    uart_cmd_parser #(
        .CLK_FREQ     (27_000_000),
        .TIMEOUT_CLKS (100),
        .RPM_MAX      (300)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .rx_data_valid_i (rx_data_valid_i),
        .rx_data_i       (rx_data_i),
        .rpm_target_o    (rpm_target_o),
        .rpm_valid_o     (rpm_valid_o),
        .frame_err_o     (frame_err_o),
        .err_code_o      (err_code_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0][7:0] frame;
        logic            exp_valid;
        logic            exp_err;
        logic [1:0]      exp_code;
        logic [15:0]     exp_target;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic strobe(input logic [7:0] b);
        @(negedge clk);
        rx_data_valid_i = 1'b1;
        rx_data_i       = b;
    endtask

    task automatic idle();
        @(negedge clk);
        rx_data_valid_i = 1'b0;
        rx_data_i       = 8'h00;
    endtask

    task automatic send_frame(input logic [4:0][7:0] f);
        for (int i = 4; i >= 0; i--) strobe(f[i]);
        idle();
    endtask

    task automatic check_result(input string name, input logic ev, input logic ee,
                                input logic [1:0] ec, input logic [15:0] et);
        chk({name, " valid"},  32'(rpm_valid_o),  32'(ev));
        chk({name, " err"},    32'(frame_err_o),  32'(ee));
        chk({name, " code"},   32'(err_code_o),   32'(ec));
        chk({name, " target"}, 32'(rpm_target_o), 32'(et));
        @(negedge clk);
        chk({name, " pulse end"}, {30'd0, rpm_valid_o, frame_err_o}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit early;

        vecs[0]  = '{40'hA5_01_00_64_65, 1'b1, 1'b0, 2'd0, 16'd100};
        vecs[1]  = '{40'hA5_01_00_64_00, 1'b0, 1'b1, 2'd1, 16'd100};
        vecs[2]  = '{40'hA5_07_00_00_07, 1'b0, 1'b1, 2'd2, 16'd100};
        vecs[3]  = '{40'hA5_01_FF_38_38, 1'b1, 1'b0, 2'd0, 16'hFF38};
        vecs[4]  = '{40'hA5_01_03_E8_EC, 1'b1, 1'b0, 2'd0, 16'h012C};
        vecs[5]  = '{40'hA5_01_FC_18_15, 1'b1, 1'b0, 2'd0, 16'hFED4};
        vecs[6]  = '{40'hA5_02_12_34_48, 1'b1, 1'b0, 2'd0, 16'h0000};
        vecs[7]  = '{40'hA5_A5_00_00_A5, 1'b0, 1'b1, 2'd2, 16'h0000};
        vecs[8]  = '{40'hA5_01_01_2C_2E, 1'b1, 1'b0, 2'd0, 16'h012C};
        vecs[9]  = '{40'hA5_01_FE_D4_D3, 1'b1, 1'b0, 2'd0, 16'hFED4};
        vecs[10] = '{40'hA5_01_80_00_81, 1'b1, 1'b0, 2'd0, 16'hFED4};

        repeat (3) @(negedge clk);
        chk("reset target", 32'(rpm_target_o), 32'd0);
        chk("reset valid",  32'(rpm_valid_o),  32'd0);
        chk("reset err",    32'(frame_err_o),  32'd0);
        chk("reset code",   32'(err_code_o),   32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 11; v++) begin
            send_frame(vecs[v].frame);
            check_result($sformatf("vec%0d", v), vecs[v].exp_valid, vecs[v].exp_err,
                         vecs[v].exp_code, vecs[v].exp_target);
        end

        // Noise before a header, all back-to-back.
        strobe(8'h00); strobe(8'hFF); strobe(8'h12);
        send_frame(40'hA5_01_00_0A_0B);
        check_result("noise", 1'b1, 1'b0, 2'd0, 16'd10);

        // Byte lands on the terminal-count cycle: no timeout.
        strobe(8'hA5); strobe(8'h01); idle();
        early = 1'b0;
        repeat (98) begin
            @(negedge clk);
            if (frame_err_o) early = 1'b1;
        end
        strobe(8'h00);
        strobe(8'h14);
        chk("term no tmo", 32'(frame_err_o), 32'd0);
        strobe(8'h15);
        idle();
        chk("term early err", 32'(early), 32'd0);
        check_result("term", 1'b1, 1'b0, 2'd0, 16'd20);

        // Reset mid-frame discards the partial frame.
        strobe(8'hA5); strobe(8'h01); strobe(8'h00);
        @(negedge clk);
        rx_data_valid_i = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst target", 32'(rpm_target_o), 32'd0);
        chk("midrst valid",  32'(rpm_valid_o),  32'd0);
        chk("midrst err",    32'(frame_err_o),  32'd0);
        chk("midrst code",   32'(err_code_o),   32'd0);
        send_frame(40'hA5_01_00_32_33);
        check_result("post rst", 1'b1, 1'b0, 2'd0, 16'd50);

        // Silence after A5 01: timeout pulse exactly 100 cycles after the last strobe.
        strobe(8'hA5); strobe(8'h01); idle();
        early = 1'b0;
        repeat (99) begin
            @(negedge clk);
            if (frame_err_o || rpm_valid_o) early = 1'b1;
        end
        chk("tmo early", 32'(early), 32'd0);
        @(negedge clk);
        chk("tmo err",    32'(frame_err_o),  32'd1);
        chk("tmo code",   32'(err_code_o),   32'd3);
        chk("tmo target", 32'(rpm_target_o), 32'd50);
        @(negedge clk);
        chk("tmo pulse end", {30'd0, frame_err_o, err_code_o != 2'd0}, 32'd0);

        send_frame(40'hA5_02_00_00_02);
        check_result("stop after tmo", 1'b1, 1'b0, 2'd0, 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
